// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: sequences the 32-bit little-endian instruction memory through
// a boot-load phase, where loader words are written one per two cycles, and a
// run phase, where the fetch stage reads it with one cycle of registered latency.
// Optional feature macro IMEM_RELOAD_EN: lets 'reload' send RUN back to LOAD.
// Without it, RUN is terminal until rst_n and 'reload' is ignored.
module imem_boot_ctrl #(
  parameter int DEPTH = 1024,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [31:0]      ld_addr,
  input  logic [31:0]      ld_data,
  input  logic             ld_last,
  input  logic             f_req,
  input  logic [31:0]      f_addr,
  output logic             f_gnt,
  output logic [31:0]      f_rdata,
  output logic             f_valid,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_din,
  output logic             mem_w,
  input  logic [31:0]      mem_dout,
  output logic             boot_done,
  output logic [CNT_W-1:0] ld_count,
  output logic             ld_err,
  input  logic             reload
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WRITE = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [31:0]      MAX_ADDR = 32'(DEPTH - 4);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  state_t           next_state;
  logic [31:0]      addr_q;
  logic [31:0]      din_q;
  logic             last_q;
  logic [CNT_W-1:0] count_q;
  logic             err_q;
  logic [31:0]      rdata_q;
  logic             valid_q;
  logic             ld_take;
  logic             ld_drop;
  logic             reload_hit;

  // A loader word is taken whenever LOAD sees ld_valid; misaligned or
  // out-of-range words are taken but dropped instead of written.
  assign ld_take = (state == LOAD) && ld_valid;
  assign ld_drop = ld_take && ((ld_addr[1:0] != 2'b00) || (ld_addr > MAX_ADDR));

`ifdef IMEM_RELOAD_EN
  assign reload_hit = (state == RUN) && reload;
`else
  logic unused_reload;
  assign unused_reload = reload;
  assign reload_hit    = 1'b0;
`endif

  // State register; async reset drops WRITE (and so mem_w) immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: LOAD -> WRITE per good word, LOAD/WRITE -> RUN on last.
  always_comb begin
    next_state = state;
    case (state)
      LOAD: begin
        if (ld_valid) begin
          if (ld_drop) begin
            next_state = ld_last ? RUN : LOAD;
          end else begin
            next_state = WRITE;
          end
        end
      end
      WRITE:   next_state = last_q ? RUN : LOAD;
      RUN:     next_state = reload_hit ? LOAD : RUN;
      default: next_state = LOAD;
    endcase
  end

  // Outputs decoded from state; the fetch port owns mem_addr only while requesting in RUN.
  always_comb begin
    ld_ready  = 1'b0;
    mem_w     = 1'b0;
    boot_done = 1'b0;
    f_gnt     = 1'b0;
    mem_addr  = addr_q;
    case (state)
      LOAD:  ld_ready = 1'b1;
      WRITE: mem_w    = 1'b1;
      RUN: begin
        boot_done = 1'b1;
        f_gnt     = f_req && !reload_hit;
        if (f_req) begin
          mem_addr = f_addr;
        end
      end
      default: ;
    endcase
  end

  // Address/data holding registers: loader captures, then last fetch address is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      din_q  <= '0;
      last_q <= 1'b0;
    end else if (ld_take && !ld_drop) begin
      addr_q <= ld_addr;
      din_q  <= ld_data;
      last_q <= ld_last;
    end else if ((state == RUN) && f_req) begin
      addr_q <= f_addr;
    end
  end

  // Written-word counter (saturating) and sticky drop flag, both cleared on reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (reload_hit) begin
        count_q <= '0;
      end else if ((state == WRITE) && (count_q != CNT_MAX)) begin
        count_q <= count_q + 1'b1;
      end
      if (reload_hit) begin
        err_q <= 1'b0;
      end else if (ld_drop) begin
        err_q <= 1'b1;
      end
    end
  end

  // Fetch return register: captures the combinational memory read on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= f_gnt;
      if (f_gnt) begin
        rdata_q <= mem_dout;
      end
    end
  end

  assign mem_din  = din_q;
  assign ld_count = count_q;
  assign ld_err   = err_q;
  assign f_rdata  = rdata_q;
  assign f_valid  = valid_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb_imem_boot_ctrl: self-checking bench for imem_boot_ctrl with a behavioural
// instruction memory and a word-level reference of what the program should hold.
// Build with IMEM_RELOAD_EN defined to exercise the reload path.
module tb_imem_boot_ctrl;

  localparam int DEPTH = 1024;
  localparam int CNT_W = 9;
  localparam int WORDS = DEPTH / 4;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             ld_valid = 1'b0;
  logic             ld_ready;
  logic [31:0]      ld_addr = '0;
  logic [31:0]      ld_data = '0;
  logic             ld_last = 1'b0;
  logic             f_req = 1'b0;
  logic [31:0]      f_addr = '0;
  logic             f_gnt;
  logic [31:0]      f_rdata;
  logic             f_valid;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_din;
  logic             mem_w;
  logic [31:0]      mem_dout;
  logic             boot_done;
  logic [CNT_W-1:0] ld_count;
  logic             ld_err;
  logic             reload = 1'b0;

  imem_boot_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_last(ld_last),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rdata(f_rdata), .f_valid(f_valid),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_w(mem_w), .mem_dout(mem_dout),
    .boot_done(boot_done), .ld_count(ld_count), .ld_err(ld_err), .reload(reload)
  );

  always #5 clk = ~clk;

  // Behavioural InstMem: synchronous write on memW, combinational read.
  logic [31:0] imem [WORDS];
  always @(posedge clk) begin
    if (mem_w) imem[mem_addr[9:2]] <= mem_din;
  end
  assign mem_dout = imem[mem_addr[9:2]];

  // Reference state: program image and the controller's expected visible state.
  logic [31:0] ref_mem [WORDS];
  bit          known [WORDS];
  int          exp_count;
  bit          exp_err;
  bit          exp_boot;
  bit          pend_valid;
  bit          pend_known;
  logic [31:0] pend_data;
  logic [31:0] last_rdata;
  bit          rdata_known;
  logic [31:0] last_addr;
  bit          hold_known;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    bit          do_rst;
    logic [31:0] addr;
    logic [31:0] data;
    bit          last;
    bit          exp_drop;
    int          exp_cnt;
    bit          exp_err;
  } vec_t;

  function automatic bit is_drop(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a > 32'(DEPTH - 4));
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_reset_values();
    check_output("rst ld_ready", 32'(ld_ready), 32'd1);
    check_output("rst f_gnt", 32'(f_gnt), 32'd0);
    check_output("rst f_valid", 32'(f_valid), 32'd0);
    check_output("rst mem_w", 32'(mem_w), 32'd0);
    check_output("rst boot_done", 32'(boot_done), 32'd0);
    check_output("rst ld_err", 32'(ld_err), 32'd0);
    check_output("rst ld_count", 32'(ld_count), 32'd0);
    check_output("rst f_rdata", f_rdata, 32'd0);
    check_output("rst mem_addr", mem_addr, 32'd0);
    check_output("rst mem_din", mem_din, 32'd0);
  endtask

  // Enters at posedge+1 (or time 0+), leaves at posedge+1 with reset released.
  task automatic do_reset();
    ld_valid = 1'b0; ld_last = 1'b0; f_req = 1'b0; reload = 1'b0;
    ld_addr = '0; ld_data = '0; f_addr = '0;
    rst_n = 1'b0;
    #2;
    check_reset_values();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_count = 0; exp_err = 1'b0; exp_boot = 1'b0;
    pend_valid = 1'b0; pend_known = 1'b0;
    last_rdata = '0; rdata_known = 1'b1;
    last_addr = '0; hold_known = 1'b1;
  endtask

  // One loader word from LOAD; optionally collides with a fetch request.
  task automatic load_word(input logic [31:0] addr, input logic [31:0] data, input bit last,
                           input bit with_freq, output bit saw_write);
    bit drop;
    drop = is_drop(addr);
    ld_valid = 1'b1; ld_addr = addr; ld_data = data; ld_last = last;
    f_req = with_freq; f_addr = addr;
    @(negedge clk);
    check_output("load ld_ready", 32'(ld_ready), 32'd1);
    check_output("load f_gnt", 32'(f_gnt), 32'd0);
    check_output("load mem_w idle", 32'(mem_w), 32'd0);
    @(posedge clk);
    #1;
    ld_valid = 1'b0; ld_last = 1'b0; f_req = 1'b0;
    @(negedge clk);
    saw_write = mem_w;
    check_output("write mem_w", 32'(mem_w), 32'(!drop));
    check_output("no f_valid in load", 32'(f_valid), 32'd0);
    if (drop) begin
      exp_err = 1'b1;
      hold_known = 1'b0;
      if (last) exp_boot = 1'b1;
    end else begin
      check_output("write mem_addr", mem_addr, addr);
      check_output("write mem_din", mem_din, data);
      check_output("write ld_ready", 32'(ld_ready), 32'd0);
      ref_mem[addr[9:2]] = data;
      known[addr[9:2]] = 1'b1;
      last_addr = addr; hold_known = 1'b1;
      if (exp_count < CNT_SAT) exp_count++;
      if (last) exp_boot = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check_output("mem_w one cycle", 32'(mem_w), 32'd0);
    end
    check_output("ld_count", 32'(ld_count), 32'(exp_count));
    check_output("ld_err", 32'(ld_err), 32'(exp_err));
    check_output("boot_done", 32'(boot_done), 32'(exp_boot));
    check_output("ld_ready after", 32'(ld_ready), 32'(!exp_boot));
    @(posedge clk);
    #1;
  endtask

  // One RUN-phase cycle: optional fetch and optional reload request.
  task automatic run_cycle(input bit req, input logic [31:0] addr, input bit rl);
    bit exp_gnt;
    f_req = req; f_addr = addr; reload = rl;
    exp_gnt = req && exp_boot;
    @(negedge clk);
    check_output("run f_gnt", 32'(f_gnt), 32'(exp_gnt));
    check_output("run boot_done", 32'(boot_done), 32'(exp_boot));
    check_output("run mem_w", 32'(mem_w), 32'd0);
    check_output("run ld_ready", 32'(ld_ready), 32'(!exp_boot));
    if (req) check_output("run mem_addr", mem_addr, addr);
    else if (hold_known) check_output("run mem_addr hold", mem_addr, last_addr);
    check_output("run f_valid", 32'(f_valid), 32'(pend_valid));
    if (pend_valid && pend_known) check_output("run f_rdata", f_rdata, pend_data);
    else if (!pend_valid && rdata_known) check_output("run f_rdata hold", f_rdata, last_rdata);
    @(posedge clk);
    #1;
    if (pend_valid) begin
      last_rdata = pend_data;
      rdata_known = pend_known;
    end
    pend_valid = exp_gnt;
    pend_data = ref_mem[addr[9:2]];
    pend_known = known[addr[9:2]] && !is_drop(addr);
    if (req) begin
      last_addr = addr; hold_known = 1'b1;
    end
`ifdef IMEM_RELOAD_EN
    if (rl && exp_boot) begin
      exp_boot = 1'b0; exp_count = 0; exp_err = 1'b0;
    end
`endif
    f_req = 1'b0; reload = 1'b0;
  endtask

  // Applies one table record and compares against its hand-derived expectations.
  task automatic apply_stimulus(input vec_t v);
    bit saw;
    if (v.do_rst) do_reset();
    load_word(v.addr, v.data, v.last, 1'b0, saw);
    check_output("table write seen", 32'(saw), 32'(!v.exp_drop));
    check_output("table ld_count", 32'(ld_count), 32'(v.exp_cnt));
    check_output("table ld_err", 32'(ld_err), 32'(v.exp_err));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[6];
    logic [31:0] group_addrs[$];
    bit saw;
    logic [31:0] a;
    int r;

    for (int i = 0; i < WORDS; i++) begin
      imem[i] = '0;
      ref_mem[i] = '0;
      known[i] = 1'b1;
    end

    vecs[0] = '{1'b1, 32'h000, 32'hAABBCCDD, 1'b0, 1'b0, 1, 1'b0};
    vecs[1] = '{1'b0, 32'h004, 32'h11223344, 1'b1, 1'b0, 2, 1'b0};
    vecs[2] = '{1'b1, 32'h002, 32'hDEADBEEF, 1'b0, 1'b1, 0, 1'b1};
    vecs[3] = '{1'b0, 32'h008, 32'h55667788, 1'b1, 1'b0, 1, 1'b1};
    vecs[4] = '{1'b1, 32'h3FC, 32'hCAFEF00D, 1'b0, 1'b0, 1, 1'b0};
    vecs[5] = '{1'b0, 32'h400, 32'h12345678, 1'b1, 1'b1, 1, 1'b1};

    #2;
    $display("[TB] table-driven boot loads");
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i]);
      if (!vecs[i].exp_drop) group_addrs.push_back(vecs[i].addr);
      if (vecs[i].last) begin
        foreach (group_addrs[k]) run_cycle(1'b1, group_addrs[k], 1'b0);
        run_cycle(1'b0, 32'h0, 1'b0);
        group_addrs.delete();
      end
    end

    $display("[TB] back-to-back fetches and loader ignored in RUN");
    run_cycle(1'b1, 32'h0, 1'b0);
    run_cycle(1'b1, 32'h4, 1'b0);
    run_cycle(1'b1, 32'h8, 1'b0);
    ld_valid = 1'b1; ld_addr = 32'h10; ld_data = 32'hFFFF0000; ld_last = 1'b1;
    run_cycle(1'b0, 32'h0, 1'b0);
    run_cycle(1'b0, 32'h0, 1'b0);
    ld_valid = 1'b0; ld_last = 1'b0;
    run_cycle(1'b1, 32'h10, 1'b0);
    run_cycle(1'b0, 32'h0, 1'b0);

    $display("[TB] reset during WRITE");
    do_reset();
    ld_valid = 1'b1; ld_addr = 32'h100; ld_data = 32'h0F0F0F0F; ld_last = 1'b0;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    #1;
    check_output("mid-write mem_w", 32'(mem_w), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("reset drops mem_w", 32'(mem_w), 32'd0);
    check_reset_values();
    known[32'h100 >> 2] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_count = 0; exp_err = 1'b0; exp_boot = 1'b0;
    pend_valid = 1'b0; pend_known = 1'b0;
    last_rdata = '0; rdata_known = 1'b1;
    last_addr = '0; hold_known = 1'b1;
    load_word(32'h006, 32'h77777777, 1'b0, 1'b1, saw);
    load_word(32'h104, 32'h89ABCDEF, 1'b1, 1'b1, saw);

    $display("[TB] fetch then reload request");
    run_cycle(1'b1, 32'h104, 1'b0);
    run_cycle(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check_output("post-reload boot_done", 32'(boot_done), 32'(exp_boot));
    check_output("post-reload ld_count", 32'(ld_count), 32'(exp_count));
    check_output("post-reload ld_err", 32'(ld_err), 32'(exp_err));
    check_output("post-reload f_valid", 32'(f_valid), 32'(pend_valid));
    @(posedge clk);
    #1;
`ifdef IMEM_RELOAD_EN
    load_word(32'h200, 32'h0BADCAFE, 1'b1, 1'b0, saw);
    run_cycle(1'b1, 32'h200, 1'b0);
    run_cycle(1'b0, 32'h0, 1'b0);
`else
    run_cycle(1'b1, 32'h104, 1'b0);
    run_cycle(1'b0, 32'h0, 1'b0);
`endif

    $display("[TB] randomized load with count saturation, then random fetches");
    do_reset();
    for (int i = 0; i < 621; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) a = {22'($urandom_range(0, 255)), 8'h00} | 32'($urandom_range(1, 3));
      else if (r == 1) a = 32'(DEPTH) + 32'(4 * $urandom_range(0, 1000));
      else a = {22'd0, 8'($urandom_range(0, WORDS - 1)), 2'b00};
      if (i == 620) a = 32'h3F0;
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        check_output("idle ld_ready", 32'(ld_ready), 32'd1);
        check_output("idle mem_w", 32'(mem_w), 32'd0);
        @(posedge clk);
        #1;
      end
      load_word(a, $urandom, (i == 620), 1'($urandom_range(0, 1)), saw);
    end
    for (int i = 0; i < 60; i++) begin
      a = {22'd0, 8'($urandom_range(0, WORDS - 1)), 2'b00};
      run_cycle(1'($urandom_range(0, 1)), a, 1'b0);
    end
    run_cycle(1'b0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
